// File: rtl/divisor_restaurador.sv
`default_nettype none
// ============================================================================
// divisor_restaurador: restoring shift-subtract divider, 2N/N -> N quotient and
//                      N remainder, one quotient bit per clock, St/Idle/Done.
// Revision: 1.0
// ============================================================================
module divisor_restaurador #(
   parameter int N = 16
) (
   input  logic           Clk,
   input  logic           Rst,
   input  logic [2*N-1:0] Dividendo,
   input  logic [N-1:0]   Divisor,
   input  logic           St,
   output logic           Idle,
   output logic           Done,
   output logic           Ovf,
   output logic [N-1:0]   Quociente,
   output logic [N-1:0]   Resto
);

   localparam int             CW       = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [N-1:0]    rem_acc, rem_acc_nx;
   logic [N-1:0]    quo_sh, quo_sh_nx;
   logic [N-1:0]    dsr, dsr_nx;
   logic [N-1:0]    quo_out_nx, rem_out_nx;
   logic            ovf_nx;

   // Trial value is one bit wider than the divisor so the compare never wraps.
   logic [N:0]      trial;
   logic            fits;
   logic [N-1:0]    rem_sub;
   logic [N-1:0]    rem_step;
   logic [N-1:0]    quo_step;

   always_comb begin
      trial    = {rem_acc, quo_sh[N-1]};
      fits     = (trial >= {1'b0, dsr});
      // When the trial fits, the difference is below dsr, so N-bit modular
      // subtraction of the low bits yields the exact remainder.
      rem_sub  = trial[N-1:0] - dsr;
      rem_step = fits ? rem_sub : trial[N-1:0];
      quo_step = {quo_sh[N-2:0], fits};
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      rem_acc_nx = rem_acc;
      quo_sh_nx  = quo_sh;
      dsr_nx     = dsr;
      quo_out_nx = Quociente;
      rem_out_nx = Resto;
      ovf_nx     = Ovf;

      case (state)
         S_IDLE: begin
            if (St) begin
               dsr_nx     = Divisor;
               rem_acc_nx = Dividendo[2*N-1:N];
               quo_sh_nx  = Dividendo[N-1:0];
               if (Dividendo[2*N-1:N] >= Divisor) begin
                  ovf_nx     = 1'b1;
                  quo_out_nx = '0;
                  rem_out_nx = '0;
                  state_nx   = S_DONE;
               end else begin
                  ovf_nx   = 1'b0;
                  cnt_nx   = CNT_LAST;
                  state_nx = S_CALC;
               end
            end
         end
         S_CALC: begin
            rem_acc_nx = rem_step;
            quo_sh_nx  = quo_step;
            if (cnt == '0) begin
               quo_out_nx = quo_step;
               rem_out_nx = rem_step;
               state_nx   = S_DONE;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         rem_acc   <= '0;
         quo_sh    <= '0;
         dsr       <= '0;
         Quociente <= '0;
         Resto     <= '0;
         Ovf       <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         rem_acc   <= rem_acc_nx;
         quo_sh    <= quo_sh_nx;
         dsr       <= dsr_nx;
         Quociente <= quo_out_nx;
         Resto     <= rem_out_nx;
         Ovf       <= ovf_nx;
      end
   end

   assign Idle = (state == S_IDLE);
   assign Done = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_divisor_restaurador.sv
`default_nettype none
// Self-checking bench for divisor_restaurador: directed cases plus random
// operands against an arithmetic reference model.
module tb_divisor_restaurador;

   localparam int N = 16;

   logic           Clk = 1'b0;
   logic           Rst = 1'b1;
   logic [2*N-1:0] Dividendo = '0;
   logic [N-1:0]   Divisor = '0;
   logic           St = 1'b0;
   logic           Idle, Done, Ovf;
   logic [N-1:0]   Quociente, Resto;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   divisor_restaurador #(.N(N)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Dividendo (Dividendo),
      .Divisor   (Divisor),
      .St        (St),
      .Idle      (Idle),
      .Done      (Done),
      .Ovf       (Ovf),
      .Quociente (Quociente),
      .Resto     (Resto)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer division with the high-half overflow rule.
   task automatic model(input logic [31:0] dvd, input logic [15:0] dvs,
                        output logic [15:0] q, output logic [15:0] r, output logic ov);
      longint unsigned a, b;
      a = longint'(dvd);
      b = longint'(dvs);
      if (dvs == 16'd0 || (a / 65536) >= b) begin
         ov = 1'b1; q = '0; r = '0;
      end else begin
         ov = 1'b0;
         q  = 16'(a / b);
         r  = 16'(a % b);
      end
   endtask

   // Called just after a falling edge; returns just after a falling edge.
   task automatic do_op(input logic [31:0] dvd, input logic [15:0] dvs, input string tag);
      logic [15:0] eq, er;
      logic        eo;
      int          k, lat;
      model(dvd, dvs, eq, er, eo);
      k = 0;
      while (!Idle && k < 40) begin @(negedge Clk); k++; end
      check({tag, " idle_before"}, 64'(Idle), 64'd1);
      Dividendo = dvd; Divisor = dvs; St = 1'b1;
      @(negedge Clk);
      St = 1'b0; Dividendo = $urandom; Divisor = 16'($urandom);
      lat = 1;
      while (!Done && lat < 40) begin
         @(negedge Clk); lat++;
         Dividendo = $urandom; Divisor = 16'($urandom);
      end
      check({tag, " latency"}, 64'(lat), eo ? 64'd1 : 64'(N + 1));
      check({tag, " done"}, 64'(Done), 64'd1);
      check({tag, " ovf"}, 64'(Ovf), 64'(eo));
      check({tag, " quo"}, 64'(Quociente), 64'(eq));
      check({tag, " rem"}, 64'(Resto), 64'(er));
      if (!eo) check({tag, " contract"}, 64'(Quociente) * 64'(dvs) + 64'(Resto), 64'(dvd));
      @(negedge Clk);
      check({tag, " idle_after"}, 64'(Idle), 64'd1);
      check({tag, " done_low"}, 64'(Done), 64'd0);
   endtask

   initial begin
      logic [31:0] dvd;
      logic [15:0] dvs, hi, eq, er;
      logic        eo, saw_done;
      logic [31:0] ops_dvd [3];
      logic [15:0] ops_dvs [3];
      int          dones, last_done, k;

      repeat (3) @(negedge Clk);
      Rst = 1'b0;
      check("reset idle", 64'(Idle), 64'd1);
      check("reset done", 64'(Done), 64'd0);
      check("reset ovf",  64'(Ovf), 64'd0);
      check("reset quo",  64'(Quociente), 64'd0);
      check("reset rem",  64'(Resto), 64'd0);

      do_op(32'd100, 16'd7, "t1");
      do_op(32'hFFFE0001, 16'hFFFF, "t2");
      do_op(32'd5, 16'd0, "t3_div0");
      do_op(32'h00010000, 16'd1, "t4_ovf");
      do_op(32'h0000FFFF, 16'd1, "t4_max");
      do_op(32'h0006FFFF, 16'd7, "t_edge");

      // Abort during the 8th CALC cycle after a nonzero result is held.
      do_op(32'd100, 16'd7, "t5_pre");
      Dividendo = 32'h12345678; Divisor = 16'hABCD; St = 1'b1;
      @(negedge Clk); St = 1'b0;
      repeat (7) @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk); Rst = 1'b0;
      check("t5 idle", 64'(Idle), 64'd1);
      check("t5 done", 64'(Done), 64'd0);
      check("t5 ovf",  64'(Ovf), 64'd0);
      check("t5 quo",  64'(Quociente), 64'd0);
      check("t5 rem",  64'(Resto), 64'd0);
      saw_done = 1'b0;
      repeat (20) begin @(negedge Clk); if (Done) saw_done = 1'b1; end
      check("t5 no_done", 64'(saw_done), 64'd0);
      do_op(32'd1000, 16'd10, "t5_post");

      // St held high for three back-to-back ops with junk operands mid-flight.
      for (int i = 0; i < 3; i++) begin
         ops_dvs[i] = 16'($urandom_range(65535, 1));
         ops_dvd[i] = {16'($urandom_range(int'(ops_dvs[i]) - 1, 0)), 16'($urandom)};
      end
      Dividendo = ops_dvd[0]; Divisor = ops_dvs[0]; St = 1'b1;
      dones = 0; last_done = 0; k = 0;
      while (dones < 3 && k < 100) begin
         @(negedge Clk); k++;
         if (Done) begin
            model(ops_dvd[dones], ops_dvs[dones], eq, er, eo);
            check("t6 quo", 64'(Quociente), 64'(eq));
            check("t6 rem", 64'(Resto), 64'(er));
            check("t6 ovf", 64'(Ovf), 64'(eo));
            if (dones > 0) check("t6 period", 64'(cyc - last_done), 64'(N + 2));
            last_done = cyc;
            dones++;
            if (dones < 3) begin
               Dividendo = ops_dvd[dones]; Divisor = ops_dvs[dones];
            end else begin
               St = 1'b0;
            end
         end else if (!Idle) begin
            Dividendo = $urandom; Divisor = 16'($urandom);
         end
      end
      check("t6 done_count", 64'(dones), 64'd3);
      @(negedge Clk);

      // Random operands: mostly in-range, some overflow, occasional zero divisor.
      for (int i = 0; i < 1500; i++) begin
         dvs = 16'($urandom);
         if ((i % 17) == 0) dvs = 16'd0;
         if (dvs != 16'd0 && ($urandom_range(3, 0) != 0))
            hi = 16'($urandom_range(int'(dvs) - 1, 0));
         else
            hi = 16'($urandom);
         dvd = {hi, 16'($urandom)};
         do_op(dvd, dvs, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
